// File: rtl/m_fc_layer_5_if.sv
// Bundle of the fully-connected stage's stream, ROM and result signals.
// The slave modport is the compute block; the master side is its environment.
interface m_fc_layer_5_if #(
    parameter int W_ADDR_W = 11,
    parameter int IDX_W    = 4
);
    logic                start;
    logic signed [15:0]  map_in;
    logic [W_ADDR_W-1:0] w_addr;
    logic signed [15:0]  w_data;
    logic [IDX_W-1:0]    b_addr;
    logic signed [15:0]  b_data;
    logic signed [15:0]  out_data;
    logic [IDX_W-1:0]    out_idx;
    logic                out_valid;
    logic                busy;
    logic                done;

    modport slave (
        input  start, map_in, w_data, b_data,
        output w_addr, b_addr, out_data, out_idx, out_valid, busy, done
    );

    modport master (
        output start, map_in, w_data, b_data,
        input  w_addr, b_addr, out_data, out_idx, out_valid, busy, done
    );
endinterface

// File: rtl/m_fc_layer_5.sv
// Layer-5 fully-connected stage: buffers one activation vector, then streams
// NUM_OUT biased, optionally rectified, saturated Q7.8 dot products.
module m_fc_layer_5 #(
    parameter int NUM_IN   = 120,
    parameter int NUM_OUT  = 10,
    parameter int W_ADDR_W = 11,
    parameter int IDX_W    = 4,
    parameter int FRAC     = 8,
    parameter int RELU     = 0
) (
    input  logic          clk_in,
    input  logic          rst_n,
    m_fc_layer_5_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_IN + 4);
    localparam int X_W   = $clog2(NUM_IN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LAST_IN = CNT_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0] C_NUM_IN  = CNT_W'(NUM_IN);
    localparam logic [CNT_W-1:0] C_ACC_LO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_ACC_HI  = CNT_W'(NUM_IN + 1);
    localparam logic [CNT_W-1:0] C_RES     = CNT_W'(NUM_IN + 2);
    localparam logic [CNT_W-1:0] C_END     = CNT_W'(NUM_IN + 3);
    localparam logic [IDX_W-1:0] J_LAST    = IDX_W'(NUM_OUT - 1);

    logic [1:0]          r_state;
    logic                r_start_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_j;
    logic [W_ADDR_W-1:0] r_w_addr;
    logic [IDX_W-1:0]    r_b_addr;
    logic signed [15:0]  r_x [NUM_IN];
    logic signed [15:0]  r_x_q;
    logic signed [31:0]  r_prod;
    logic signed [39:0]  r_acc;
    logic signed [15:0]  r_out_data;
    logic [IDX_W-1:0]    r_out_idx;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_start_edge;
    logic [X_W-1:0]      w_x_idx;
    logic signed [39:0]  w_bias_ext;
    logic signed [39:0]  w_sum;
    logic signed [39:0]  w_shift;
    logic signed [15:0]  w_sat;

    assign w_start_edge = bus.start & ~r_start_d;
    assign w_x_idx      = r_cnt[X_W-1:0];

    // Bias is Q7.8 while the accumulator carries 2*FRAC fraction bits.
    assign w_bias_ext = {{24{bus.b_data[15]}}, bus.b_data};
    assign w_sum      = r_acc + (w_bias_ext <<< FRAC);
    assign w_shift    = w_sum >>> FRAC;

    // NOTE: every branch of a combinational block must assign, else a latch is inferred.
    always_comb begin
        w_sat = w_shift[15:0];
        if ((RELU != 0) && (w_shift < 40'sd0))
            w_sat = 16'sd0;
        else if (w_shift > 40'sd32767)
            w_sat = 16'sh7FFF;
        else if (w_shift < -40'sd32768)
            w_sat = 16'sh8000;
    end

    // NOTE: the activation buffer is storage, not control; it is left unreset.
    always_ff @(posedge clk_in) begin
        if (r_state == S_LOAD)
            r_x[w_x_idx] <= bus.map_in;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_start_d   <= 1'b1;  // a start already high at release is not an edge
            r_cnt       <= '0;
            r_j         <= '0;
            r_w_addr    <= '0;
            r_b_addr    <= '0;
            r_x_q       <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start_d   <= bus.start;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_prod      <= 32'(r_x_q) * 32'(bus.w_data);
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == C_LAST_IN) begin
                        r_state  <= S_CALC;
                        r_cnt    <= '0;
                        r_j      <= '0;
                        r_w_addr <= '0;
                        r_b_addr <= '0;
                    end else begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + C_ONE;
                    if (r_cnt < C_NUM_IN)
                        r_x_q <= r_x[w_x_idx];
                    if (r_cnt < C_LAST_IN)
                        r_w_addr <= r_w_addr + W_ADDR_W'(1);
                    // Product lags the address by two cycles: ROM latency plus x_q.
                    if (r_cnt == '0)
                        r_acc <= '0;
                    else if ((r_cnt >= C_ACC_LO) && (r_cnt <= C_ACC_HI))
                        r_acc <= r_acc + 40'(r_prod);
                    if (r_cnt == C_RES) begin
                        r_out_data  <= w_sat;
                        r_out_idx   <= r_j;
                        r_out_valid <= 1'b1;
                    end
                    if (r_cnt == C_END) begin
                        r_cnt <= '0;
                        if (r_j == J_LAST) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_w_addr <= '0;
                            r_b_addr <= '0;
                        end else begin
                            r_j      <= r_j + IDX_W'(1);
                            r_w_addr <= r_w_addr + W_ADDR_W'(1);
                            r_b_addr <= r_b_addr + IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.w_addr    = r_w_addr;
    assign bus.b_addr    = r_b_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_m_fc_layer_5.sv
// Bench for m_fc_layer_5: RELU=0 and RELU=1 instances share stimulus and are
// compared every cycle against a dot-product model and a timing schedule.
module tb_m_fc_layer_5;
    localparam int NUM_IN   = 120;
    localparam int NUM_OUT  = 10;
    localparam int W_ADDR_W = 11;
    localparam int IDX_W    = 4;
    localparam int NW       = NUM_IN * NUM_OUT;
    localparam int CALC_OFF = NUM_IN;
    localparam int PERIOD   = NUM_IN + 4;
    localparam int FIRST    = 2 * NUM_IN + 3;
    localparam int DONE_OFF = FIRST + PERIOD * (NUM_OUT - 1) + 1;
    localparam int ABORT_AT = CALC_OFF + PERIOD * 4 + 60;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    m_fc_layer_5_if #(.W_ADDR_W(W_ADDR_W), .IDX_W(IDX_W)) bus0 ();
    m_fc_layer_5_if #(.W_ADDR_W(W_ADDR_W), .IDX_W(IDX_W)) bus1 ();

    m_fc_layer_5 #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .W_ADDR_W(W_ADDR_W),
                   .IDX_W(IDX_W), .FRAC(8), .RELU(0))
        dut0 (.clk_in(clk_in), .rst_n(rst_n), .bus(bus0));
    m_fc_layer_5 #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .W_ADDR_W(W_ADDR_W),
                   .IDX_W(IDX_W), .FRAC(8), .RELU(1))
        dut1 (.clk_in(clk_in), .rst_n(rst_n), .bus(bus1));

    int                 x_v [NUM_IN];
    logic signed [15:0] w_mem [NW];
    logic signed [15:0] b_mem [16];

    // Synchronous ROMs with one cycle of latency.
    always @(posedge clk_in) begin
        bus0.w_data <= w_mem[bus0.w_addr];
        bus0.b_data <= b_mem[bus0.b_addr];
        bus1.w_data <= w_mem[bus1.w_addr];
        bus1.b_data <= b_mem[bus1.b_addr];
    end

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    always @(posedge clk_in) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_out(input int j, input bit relu);
        longint acc = 0;
        longint r;
        for (int k = 0; k < NUM_IN; k++)
            acc += longint'(x_v[k]) * longint'(w_mem[j*NUM_IN + k]);
        acc += longint'(b_mem[j]) * 256;
        r = (acc >= 0) ? acc / 256 : -((-acc + 255) / 256);
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic drive_start(input bit v);
        bus0.start = v;
        bus1.start = v;
    endtask

    task automatic drive_map(input int v);
        bus0.map_in = 16'(v);
        bus1.map_in = 16'(v);
    endtask

    bit run_on = 1'b0;
    int t_edge = 0;
    int exp0 [NUM_OUT];
    int exp1 [NUM_OUT];
    int got0 [NUM_OUT];
    int got1 [NUM_OUT];
    int cmp_d, cmp_j, cmp_p, cmp_k;
    bit cmp_v;

    // Per-cycle comparison against the expected schedule of the current run.
    always @(negedge clk_in) begin
        if (run_on) begin
            cmp_d = edge_cnt - t_edge;
            cmp_v = (cmp_d >= FIRST) && ((cmp_d - FIRST) % PERIOD == 0)
                    && ((cmp_d - FIRST) / PERIOD < NUM_OUT);
            cmp_j = (cmp_d - FIRST) / PERIOD;
            check("valid0", bus0.out_valid, cmp_v);
            check("valid1", bus1.out_valid, cmp_v);
            if (cmp_v) begin
                check("idx0", bus0.out_idx, cmp_j);
                check("idx1", bus1.out_idx, cmp_j);
                check("data0", bus0.out_data, exp0[cmp_j]);
                check("data1", bus1.out_data, exp1[cmp_j]);
                got0[cmp_j] = bus0.out_data;
                got1[cmp_j] = bus1.out_data;
            end
            check("busy0", bus0.busy, (cmp_d >= 0) && (cmp_d <= DONE_OFF));
            check("busy1", bus1.busy, (cmp_d >= 0) && (cmp_d <= DONE_OFF));
            check("done0", bus0.done, cmp_d == DONE_OFF);
            check("done1", bus1.done, cmp_d == DONE_OFF);
            if (cmp_d >= CALC_OFF) begin
                cmp_p = (cmp_d - CALC_OFF) / PERIOD;
                cmp_k = (cmp_d - CALC_OFF) % PERIOD;
                if (cmp_p < NUM_OUT) begin
                    if (cmp_k < NUM_IN)
                        check("w_addr", bus0.w_addr, cmp_p * NUM_IN + cmp_k);
                    check("b_addr", bus0.b_addr, cmp_p);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_data0"},  bus0.out_data, 0);
        check({tag, "_idx0"},   bus0.out_idx, 0);
        check({tag, "_valid0"}, bus0.out_valid, 0);
        check({tag, "_busy0"},  bus0.busy, 0);
        check({tag, "_done0"},  bus0.done, 0);
        check({tag, "_waddr0"}, bus0.w_addr, 0);
        check({tag, "_baddr0"}, bus0.b_addr, 0);
        check({tag, "_data1"},  bus1.out_data, 0);
        check({tag, "_busy1"},  bus1.busy, 0);
        check({tag, "_valid1"}, bus1.out_valid, 0);
    endtask

    task automatic do_run(input bit hold_start, input bit poke_start, input int abort_at);
        int d;
        for (int j = 0; j < NUM_OUT; j++) begin
            exp0[j] = ref_out(j, 1'b0);
            exp1[j] = ref_out(j, 1'b1);
            got0[j] = -99999;
            got1[j] = -99999;
        end
        @(negedge clk_in);
        drive_start(1'b1);
        t_edge = edge_cnt + 1;
        run_on = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            @(negedge clk_in);
            drive_map(x_v[k]);
            if (k == 2 && !hold_start) drive_start(1'b0);
        end
        for (int c = 0; c < DONE_OFF + 8; c++) begin
            @(negedge clk_in);
            d = edge_cnt - t_edge;
            if (poke_start && d == 500) drive_start(1'b1);
            if (poke_start && d == 510) drive_start(1'b0);
            if (d == abort_at) begin
                run_on = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_all_zero("abort");
                repeat (3) @(negedge clk_in);
                rst_n = 1'b1;
                return;
            end
            if (d > DONE_OFF + 3) break;
        end
        run_on = 1'b0;
    endtask

    task automatic fill(input int xv, input int wv);
        for (int k = 0; k < NUM_IN; k++) x_v[k] = xv;
        for (int a = 0; a < NW; a++) w_mem[a] = 16'(wv);
        for (int j = 0; j < 16; j++) b_mem[j] = '0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < NUM_IN; k++) x_v[k] = int'($urandom_range(0, 1023)) - 512;
        for (int a = 0; a < NW; a++) w_mem[a] = 16'(int'($urandom_range(0, 1023)) - 512);
        for (int j = 0; j < NUM_OUT; j++) b_mem[j] = 16'($urandom_range(0, 65535));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_start(1'b1);
        drive_map(0);
        fill(0, 0);
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk_in);
            check("start_high_at_release", bus0.busy, 0);
        end
        drive_start(1'b0);
        @(negedge clk_in);

        // All ones in Q7.8 with start held high through done.
        fill(256, 256);
        do_run(1'b1, 1'b0, -1);
        for (int j = 0; j < NUM_OUT; j++) begin
            check("lit_ones0", got0[j], 30720);
            check("lit_ones1", got1[j], 30720);
        end
        repeat (40) begin
            @(negedge clk_in);
            check("held_start_busy", bus0.busy, 0);
            check("held_start_valid", bus0.out_valid, 0);
        end
        drive_start(1'b0);
        @(negedge clk_in);

        fill(256, 512);
        do_run(1'b0, 1'b0, -1);
        check("lit_possat0", got0[0], 32767);
        check("lit_possat1", got1[9], 32767);

        fill(256, -512);
        do_run(1'b0, 1'b0, -1);
        check("lit_negsat0", got0[3], -32768);
        check("lit_relu1", got1[3], 0);

        fill(0, 0);
        for (int j = 0; j < NUM_OUT; j++) b_mem[j] = 16'(j * 100);
        do_run(1'b0, 1'b0, -1);
        for (int j = 0; j < NUM_OUT; j++) check("lit_bias", got0[j], j * 100);

        fill(0, 0);
        x_v[0] = 1;
        w_mem[0] = 16'sd1;
        w_mem[NUM_IN] = -16'sd1;
        do_run(1'b0, 1'b0, -1);
        check("lit_floor_pos", got0[0], 0);
        check("lit_floor_neg", got0[1], -1);
        check("lit_floor_relu", got1[1], 0);

        fill_random();
        do_run(1'b0, 1'b1, -1);

        fill_random();
        do_run(1'b0, 1'b0, ABORT_AT);
        fill_random();
        do_run(1'b0, 1'b0, -1);
        check("restart_idx_seen", got0[0], exp0[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/m_fc_layer_5.md
Name: m_fc_layer_5

Overview:
- Fully-connected compute stage directly downstream of the layer-5 input buffer.
- Captures one streamed vector of NUM_IN signed 16-bit activations, then computes NUM_OUT dot products against weights in an external synchronous ROM.
- Adds a per-neuron bias, applies optional ReLU, saturates, and emits one 16-bit result per neuron with an index tag.
- Results feed the classifier/argmax stage.

Parameters:
- NUM_IN, 120, number of input activations per vector.
- NUM_OUT, 10, number of output neurons.
- W_ADDR_W, 11, weight ROM address width (must hold NUM_IN*NUM_OUT-1).
- IDX_W, 4, width of neuron index (must hold NUM_OUT-1).
- FRAC, 8, fractional bits of the fixed-point format (Q7.8).
- RELU, 0, 1 = clamp negative results to 0.

Ports:
- clk_in  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  upstream k_ready; the rising edge begins a vector, level otherwise ignored
- map_in  in  16  signed activation stream from upstream
- w_addr  out  W_ADDR_W  weight ROM address
- w_data  in  16  signed weight, valid the cycle after w_addr
- b_addr  out  IDX_W  bias ROM address
- b_data  in  16  signed Q7.8 bias, valid the cycle after b_addr
- out_data  out  16  signed Q7.8 neuron result
- out_idx  out  IDX_W  neuron index of out_data
- out_valid  out  1  one-cycle strobe per result
- busy  out  1  high from start-edge detection until done
- done  out  1  one-cycle strobe after the last result

Behaviour:
- Reset (asynchronous, any time, including mid-vector): state=IDLE; all counters, accumulator and buffer pointer cleared; out_data=0, out_idx=0, out_valid=0, busy=0, done=0, w_addr=0, b_addr=0. After release, the block waits for a fresh start rising edge. A start already high at release is not an edge.
- Edge detect: start_d is registered. An edge is start=1 & start_d=0 in cycle t. It is accepted only in IDLE; edges in any other state are ignored.
- States:
  - IDLE: wait for the edge, then go to LOAD. busy goes high the cycle after t.
  - LOAD: element k arrives on map_in in cycle t+1+k, k=0..NUM_IN-1, and is written to local buffer x[k] (distributed RAM/regs). After k=NUM_IN-1, go to CALC with j=0.
  - CALC: one neuron per pass, NUM_IN+4 cycles. Cycles are relative to pass start.
    - Cycle 0: accumulator cleared; b_addr=j for the whole pass.
    - Cycles 0..NUM_IN-1: w_addr=j*NUM_IN+k; x[k] read into a register.
    - Cycle k+1: product p=x_q*w_data (32-bit signed) registered.
    - Cycle k+2: acc (40-bit signed) += p.
    - Cycle NUM_IN+2: r = (acc + (b_data sign-extended <<FRAC)) >>> FRAC, arithmetic shift, floor. If RELU and r<0, r=0. Saturate to [-32768, 32767]. Register out_data=r, out_idx=j, out_valid=1.
    - Cycle NUM_IN+3: out_valid=1 visible; then j++. If j was NUM_OUT-1, go to DONE; otherwise start the next pass.
  - DONE: done=1 for one cycle, busy=0, back to IDLE.
- out_data and out_idx hold their last values between strobes.
- First out_valid occurs in cycle t+1+NUM_IN+NUM_IN+3. Consecutive out_valid strobes are NUM_IN+4 cycles apart. done occurs the cycle after the last out_valid.
- Worst-case accumulator magnitude is 120*2^30, so 40 bits never overflows. Saturation is applied only at the output.
- w_addr and b_addr are registered outputs; the ROM latency is exactly 1 cycle.

Test Plan:
- All x=256, all w=256, bias=0, RELU=0 -> 10 strobes, out_data=30720 (0x7800), out_idx 0..9 in order; done 1 cycle after idx 9.
- x=256, w=512 -> 32767 (positive saturation). w=-512 -> -32768. RELU=1 with w=-512 -> 0.
- x=0, bias[j]=j*100 -> out_data=j*100 for j=0..9. Rounding check: single x=1, w=1, others 0, bias 0 -> 0; w=-1 -> -1 (floor).
- Timing: start edge in cycle t -> first out_valid exactly in cycle t+244, period 124, busy high from t+1 through the done cycle. w_addr sequence 0..119 for j=0, then 120..239 for j=1.
- Start toggled low/high during CALC -> ignored, results unchanged. start held high after done -> no new run until it falls and rises again.
- rst_n asserted mid-CALC (j=4) -> all outputs 0 immediately (asynchronous). After release and a new start edge, a full correct 10-result run with out_idx restarting at 0.
